dmem_responder: RTL and testbench

Handshaked data-memory responder serving the load/store port of the pipelined MIPS core (or any initiator using the same request/response protocol). It accepts one word request at a time, inserts a programmable number of wait states, performs the read or write on internal word storage, and holds the response until the initiator takes it. It is the memory side of the core's data interface and replaces the zero-latency combinational data memory when memory latency must be modelled.

---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 tb/tb_dmem_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder with programmable wait states.
// One request in flight; response held until the initiator takes it.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;

    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;

    logic [31:0]     mem [DEPTH];

    logic            access;
    logic            mem_we;
    logic            acc_we;
    logic            acc_err;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic            req_err;

    // Misaligned or beyond the implemented word range.
    assign req_err = (req_addr[1:0] != 2'b00)
                   || (req_addr[31:AW+2] != '0);

    // Next-state, capture and access selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        access      = 1'b0;
        mem_we      = 1'b0;
        acc_we      = we_q;
        acc_err     = err_q;
        acc_idx     = idx_q;
        acc_wdata   = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    idx_d       = req_addr[AW+1:2];
                    wdata_d     = req_wdata;
                    err_d       = req_err;
                    req_ready_d = 1'b0;
                    if (LAT == 4'd0) begin
                        // Zero latency: access on the accept edge
                        // straight from the request bus.
                        state_d   = S_RESP;
                        access    = 1'b1;
                        acc_we    = req_we;
                        acc_err   = req_err;
                        acc_idx   = req_addr[AW+1:2];
                        acc_wdata = req_wdata;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (access) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
            mem_we      = acc_we && !acc_err;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset clears any pending request.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Word storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Three instances: LATENCY 2, 0 and 3, DEPTH 256.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        clr       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [3][256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH  (256),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .clr      (clr[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g]),
            .busy     (busy[g])
        );
    end

    function automatic int lat(input int d);
        return d == 0 ? 2 : (d == 1 ? 0 : 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one accepted request; pushes the expectation.
    task automatic predict(input int d, input logic we,
                           input logic [31:0] addr,
                           input logic [31:0] wdata);
        exp_t e;
        e.err = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (we) model[d][addr[9:2]] = wdata;
            else    e.rdata = model[d][addr[9:2]];
        end
        sb.push_back(e);
    endtask

    task automatic run_txn(input int d, input logic we,
                           input logic [31:0] addr,
                           input logic [31:0] wdata,
                           input int hold);
        int k;
        exp_t e;
        k = 0;
        while (!req_ready[d] && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (!req_ready[d]) begin
            errors++;
            $display("FAIL req_ready_timeout d%0d got 0 want 1", d);
            return;
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        predict(d, we, addr, wdata);
        tick();
        req_valid[d] = 1'b0;
        k = 0;
        while (!rsp_valid[d] && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (k != lat(d)) begin
            errors++;
            $display("FAIL latency d%0d addr %h got %0d want %0d",
                     d, addr, k, lat(d));
        end
        e = sb.pop_front();
        checks++;
        if (rsp_rdata[d] !== e.rdata || rsp_err[d] !== e.err) begin
            errors++;
            $display("FAIL rsp d%0d addr %h got %h/%b want %h/%b",
                     d, addr, rsp_rdata[d], rsp_err[d], e.rdata, e.err);
        end
        repeat (hold) tick();
        rsp_ready[d] = 1'b1;
        tick();
        rsp_ready[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1
            || busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL take d%0d got v%b r%b b%b want v0 r1 b0",
                     d, rsp_valid[d], req_ready[d], busy[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            clr[d]       = 1'b0;
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b1;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'hFFFF_FFFF;
            rsp_ready[d] = 1'b0;
        end
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0
                || rsp_rdata[d] !== 32'd0 || rsp_err[d] !== 1'b0
                || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out d%0d got r%b v%b d%h e%b b%b want 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d],
                         rsp_err[d], busy[d]);
            end
        end
        for (int d = 0; d < 3; d++) clr[d] = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || busy[d] !== 1'b0
                || rsp_valid[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release d%0d got r%b b%b v%b want r1 b0 v0",
                         d, req_ready[d], busy[d], rsp_valid[d]);
            end
            req_valid[d] = 1'b0;
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_accept d%0d got busy %b want 0",
                         d, busy[d]);
            end
        end
    endtask

    task automatic test_store_load();
        run_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        run_txn(0, 1'b0, 32'h10, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        int last;
        int n;
        int seen;
        exp_t e;
        last = -1;
        n = 0;
        seen = 0;
        rsp_ready[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h10;
        req_valid[0] = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (rsp_valid[0]) begin
                seen++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got rsp at cycle %0d want none",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    if (rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err) begin
                        errors++;
                        $display("FAIL b2b_rsp got %h/%b want %h/%b",
                                 rsp_rdata[0], rsp_err[0], e.rdata, e.err);
                    end
                end
            end
            if (n >= 4) req_valid[0] = 1'b0;
            if (req_valid[0] && req_ready[0]) begin
                predict(0, 1'b0, 32'h10, 32'h0);
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 4) begin
                        errors++;
                        $display("FAIL b2b_period got %0d want 4", cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
            tick();
        end
        rsp_ready[0] = 1'b0;
        checks++;
        if (seen != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count got %0d rsps want 4", seen);
            sb.delete();
        end
    endtask

    task automatic test_backpressure();
        int k;
        exp_t e;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h10;
        predict(0, 1'b0, 32'h10, 32'h0);
        tick();
        req_valid[0] = 1'b0;
        k = 0;
        while (!rsp_valid[0] && k < 20) begin
            tick();
            k++;
        end
        e = sb.pop_front();
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.rdata) begin
            errors++;
            $display("FAIL bp_first got %b/%h want 1/%h",
                     rsp_valid[0], rsp_rdata[0], e.rdata);
        end
        for (int i = 0; i < 5; i++) begin
            req_valid[0] = (i % 2 == 0);
            req_addr[0]  = 32'h40 + 32'(4 * i);
            req_we[0]    = i[0];
            req_wdata[0] = 32'h5A5A_0000 + 32'(i);
            tick();
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.rdata
                || req_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c%0d got v%b d%h r%b want v1 d%h r0",
                         i, rsp_valid[0], rsp_rdata[0], req_ready[0], e.rdata);
            end
        end
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_take got v%b r%b want v0 r1",
                     rsp_valid[0], req_ready[0]);
        end
        repeat (3) tick();
        checks++;
        if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_extra got v%b b%b want 0 0",
                     rsp_valid[0], busy[0]);
        end
    endtask

    task automatic test_errors();
        run_txn(0, 1'b1, 32'h0,   32'hCAFE_F00D, 0);
        run_txn(0, 1'b0, 32'h13,  32'h0, 1);
        run_txn(0, 1'b1, 32'h400, 32'h5555_5555, 0);
        run_txn(0, 1'b0, 32'h0,   32'h0, 0);
    endtask

    task automatic test_lat0();
        for (int i = 0; i < 4; i++)
            run_txn(1, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i * 17), 0);
        for (int i = 0; i < 4; i++)
            run_txn(1, 1'b0, 32'(4 * i), 32'h0, 0);
    endtask

    task automatic test_reset_mid();
        run_txn(2, 1'b1, 32'h20, 32'h1111_1111, 0);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'h1234_5678;
        tick();
        req_valid[2] = 1'b0;
        tick();
        checks++;
        if (busy[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait got b%b v%b want b1 v0",
                     busy[2], rsp_valid[2]);
        end
        clr[2] = 1'b0;
        #1;
        checks++;
        if (busy[2] !== 1'b0 || req_ready[2] !== 1'b0
            || rsp_valid[2] !== 1'b0 || rsp_err[2] !== 1'b0
            || rsp_rdata[2] !== 32'd0) begin
            errors++;
            $display("FAIL mid_clear got b%b r%b v%b e%b d%h want 0",
                     busy[2], req_ready[2], rsp_valid[2], rsp_err[2],
                     rsp_rdata[2]);
        end
        repeat (3) tick();
        clr[2] = 1'b1;
        tick();
        run_txn(2, 1'b0, 32'h20, 32'h0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_lat0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
